// File: rtl/phone_disp_scroll.sv
// Scrolling 8-digit window over an 11-digit BCD phone number, driving a
// multiplexed common-anode 7-segment display; a keypress parks the window on the newest digits.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SCROLL | window advances one digit per scroll tick, wrapping 3 -> 0
// HOLD   | window parked at offset 3 until hold_cnt scroll ticks pass
module phone_disp_scroll #(
   parameter int SCAN_DIV   = 50_000,
   parameter int SCROLL_DIV = 25_000_000,
   parameter int HOLD_TICKS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_flag,
   input  logic [43:0] phone_number,
   output logic [7:0]  seg,
   output logic [7:0]  sel,
   output logic [1:0]  win_offset
);

   localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int HOLD_W   = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

   localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
   localparam logic [HOLD_W-1:0]   HOLD_LOAD   = HOLD_W'(HOLD_TICKS);

   typedef enum logic {
      ST_SCROLL = 1'b0,
      ST_HOLD   = 1'b1
   } state_t;

   logic [SCAN_W-1:0]   scan_cnt;
   logic [SCROLL_W-1:0] scroll_cnt;
   logic                scan_tick;
   logic                scroll_tick;
   logic [2:0]          pos;

   state_t              state_q;
   state_t              state_d;
   logic [1:0]          win_q;
   logic [1:0]          win_d;
   logic [HOLD_W-1:0]   hold_q;
   logic [HOLD_W-1:0]   hold_d;

   logic [3:0]          digit_idx;
   logic [3:0]          digit;

   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   assign scan_tick   = (scan_cnt == SCAN_LAST);
   assign scroll_tick = (scroll_cnt == SCROLL_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         pos      <= 3'd0;
      end else if (scan_tick) begin
         scan_cnt <= '0;
         pos      <= pos + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

   // Clearing on key_flag makes the hold last exactly HOLD_TICKS full periods.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scroll_cnt <= '0;
      end else if (key_flag || scroll_tick) begin
         scroll_cnt <= '0;
      end else begin
         scroll_cnt <= scroll_cnt + SCROLL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_SCROLL;
         win_q   <= 2'd0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      hold_d  = hold_q;
      if (key_flag) begin
         state_d = ST_HOLD;
         win_d   = 2'd3;
         hold_d  = HOLD_LOAD;
      end else begin
         case (state_q)
            ST_SCROLL: begin
               if (scroll_tick) begin
                  win_d = (win_q == 2'd3) ? 2'd0 : win_q + 2'd1;
               end
            end
            ST_HOLD: begin
               win_d = 2'd3;
               if (scroll_tick) begin
                  if (hold_q <= HOLD_W'(1)) begin
                     state_d = ST_SCROLL;
                     win_d   = 2'd0;
                     hold_d  = '0;
                  end else begin
                     hold_d = hold_q - HOLD_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_SCROLL;
               win_d   = 2'd0;
               hold_d  = '0;
            end
         endcase
      end
   end

   assign digit_idx = {2'b00, win_q} + {1'b0, pos};

   // Indices past 10 cannot occur (w<=3, p<=7) but decode to blank anyway.
   always_comb begin
      digit = 4'hF;
      for (int i = 0; i < 11; i++) begin
         if (digit_idx == 4'(i)) begin
            digit = phone_number[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= 8'hFF;
         sel <= 8'hFF;
      end else begin
         seg <= seg_decode(digit);
         sel <= ~(8'h80 >> pos);
      end
   end

   assign win_offset = win_q;

endmodule

// File: tb/tb_phone_disp_scroll.sv
// Directed bench for phone_disp_scroll with small dividers: vector tables of
// {edge, key, number, sel, seg, window} plus hand sequences around reset.
module tb_phone_disp_scroll;

   localparam logic [43:0] NUM_Z = 44'h0;
   localparam logic [43:0] NUM_P = 44'h98765432101;
   localparam logic [43:0] NUM_Q = 44'h98765B32101;

   logic        clk;
   logic        rst_n;
   logic        key_flag;
   logic [43:0] phone_number;
   logic [7:0]  seg;
   logic [7:0]  sel;
   logic [1:0]  win_offset;

   int n_tests;
   int n_fail;
   int edge_cnt;

   typedef struct {
      int          edge_n;
      logic        key;
      logic [43:0] phone;
      logic [7:0]  sel;
      logic [7:0]  seg;
      logic [1:0]  win;
      logic        chk;
   } vec_t;

   vec_t vecs[$];

   phone_disp_scroll #(
      .SCAN_DIV   (4),
      .SCROLL_DIV (64),
      .HOLD_TICKS (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_flag     (key_flag),
      .phone_number (phone_number),
      .seg          (seg),
      .sel          (sel),
      .win_offset   (win_offset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input int e, input logic k, input logic [43:0] ph,
                      input logic [7:0] sl, input logic [7:0] sg,
                      input logic [1:0] w, input logic c);
      vec_t v;
      v.edge_n = e; v.key = k; v.phone = ph;
      v.sel = sl; v.seg = sg; v.win = w; v.chk = c;
      vecs.push_back(v);
   endtask

   task automatic wait_edge(input int target);
      int guard;
      guard = 0;
      while (edge_cnt < target && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (edge_cnt != target) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_edge: at edge %0d, expected edge %0d", edge_cnt, target);
      end
   endtask

   task automatic run_vecs();
      foreach (vecs[i]) begin
         wait_edge(vecs[i].edge_n - 1);
         key_flag     = vecs[i].key;
         phone_number = vecs[i].phone;
         @(negedge clk);
         key_flag = 1'b0;
         check($sformatf("win@%0d", vecs[i].edge_n), {6'd0, win_offset}, {6'd0, vecs[i].win});
         if (vecs[i].chk) begin
            check($sformatf("sel@%0d", vecs[i].edge_n), sel, vecs[i].sel);
            check($sformatf("seg@%0d", vecs[i].edge_n), seg, vecs[i].seg);
         end
      end
      vecs.delete();
   endtask

   task automatic do_reset(input logic [43:0] ph);
      rst_n        = 1'b0;
      key_flag     = 1'b0;
      phone_number = ph;
      repeat (3) @(negedge clk);
      check("rst_seg", seg, 8'hFF);
      check("rst_sel", sel, 8'hFF);
      check("rst_win", {6'd0, win_offset}, 8'h00);
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      key_flag     = 1'b0;
      phone_number = NUM_Z;

      // All-zero number: each position held 4 clocks, every digit shows 0.
      do_reset(NUM_Z);
      add( 1, 0, NUM_Z, 8'h7F, 8'hC0, 0, 1);
      add( 4, 0, NUM_Z, 8'h7F, 8'hC0, 0, 1);
      add( 5, 0, NUM_Z, 8'hBF, 8'hC0, 0, 1);
      add( 9, 0, NUM_Z, 8'hDF, 8'hC0, 0, 1);
      add(13, 0, NUM_Z, 8'hEF, 8'hC0, 0, 1);
      add(17, 0, NUM_Z, 8'hF7, 8'hC0, 0, 1);
      add(21, 0, NUM_Z, 8'hFB, 8'hC0, 0, 1);
      add(25, 0, NUM_Z, 8'hFD, 8'hC0, 0, 1);
      add(29, 0, NUM_Z, 8'hFE, 8'hC0, 0, 1);
      add(32, 0, NUM_Z, 8'hFE, 8'hC0, 0, 1);
      add(33, 0, NUM_Z, 8'h7F, 8'hC0, 0, 1);
      run_vecs();

      do_reset(NUM_P);
      // free-run scroll, window 0 shows 1,0,1,2,3,4,5,6
      add(  1, 0, NUM_P, 8'h7F, 8'hF9, 0, 1);
      add(  5, 0, NUM_P, 8'hBF, 8'hC0, 0, 1);
      add(  9, 0, NUM_P, 8'hDF, 8'hF9, 0, 1);
      add( 13, 0, NUM_P, 8'hEF, 8'hA4, 0, 1);
      add( 17, 0, NUM_P, 8'hF7, 8'hB0, 0, 1);
      add( 21, 0, NUM_P, 8'hFB, 8'h99, 0, 1);
      add( 25, 0, NUM_P, 8'hFD, 8'h92, 0, 1);
      add( 29, 0, NUM_P, 8'hFE, 8'h82, 0, 1);
      add( 63, 0, NUM_P, 8'h00, 8'h00, 0, 0);
      add( 64, 0, NUM_P, 8'hFE, 8'h82, 1, 1);
      add( 65, 0, NUM_P, 8'h7F, 8'hC0, 1, 1);
      add(127, 0, NUM_P, 8'h00, 8'h00, 1, 0);
      add(128, 0, NUM_P, 8'h00, 8'h00, 2, 0);
      add(192, 0, NUM_P, 8'h00, 8'h00, 3, 0);
      add(193, 0, NUM_P, 8'h7F, 8'hA4, 3, 1);
      add(255, 0, NUM_P, 8'h00, 8'h00, 3, 0);
      add(256, 0, NUM_P, 8'h00, 8'h00, 0, 0);
      add(320, 0, NUM_P, 8'h00, 8'h00, 1, 0);
      // key at w=1: jump to 3, show digits 3..10, release 128 clocks later
      add(330, 1, NUM_P, 8'hDF, 8'hA4, 3, 1);
      add(331, 0, NUM_P, 8'hDF, 8'h99, 3, 1);
      add(353, 0, NUM_P, 8'h7F, 8'hA4, 3, 1);
      add(357, 0, NUM_P, 8'hBF, 8'hB0, 3, 1);
      add(381, 0, NUM_P, 8'hFE, 8'h90, 3, 1);
      add(457, 0, NUM_P, 8'h00, 8'h00, 3, 0);
      add(458, 0, NUM_P, 8'h00, 8'h00, 0, 0);
      add(521, 0, NUM_P, 8'h00, 8'h00, 0, 0);
      add(522, 0, NUM_P, 8'h00, 8'h00, 1, 0);
      // second key 100 clocks into the hold restarts it
      add(540, 1, NUM_P, 8'h00, 8'h00, 3, 0);
      add(639, 0, NUM_P, 8'h00, 8'h00, 3, 0);
      add(640, 1, NUM_P, 8'h00, 8'h00, 3, 0);
      add(668, 0, NUM_P, 8'h00, 8'h00, 3, 0);
      add(767, 0, NUM_P, 8'h00, 8'h00, 3, 0);
      add(768, 0, NUM_P, 8'h00, 8'h00, 0, 0);
      add(831, 0, NUM_P, 8'h00, 8'h00, 0, 0);
      add(832, 0, NUM_P, 8'h00, 8'h00, 1, 0);
      add(895, 0, NUM_P, 8'h00, 8'h00, 1, 0);
      // key coincident with scroll tick: key wins, no increment
      add(896, 1, NUM_P, 8'h00, 8'h00, 3, 0);
      add(960, 0, NUM_P, 8'h00, 8'h00, 3, 0);
      add(1023, 0, NUM_P, 8'h00, 8'h00, 3, 0);
      add(1024, 0, NUM_P, 8'h00, 8'h00, 0, 0);
      // digit 5 replaced by a non-BCD code blanks its position
      add(1041, 0, NUM_Q, 8'hF7, 8'hB0, 0, 1);
      add(1045, 0, NUM_Q, 8'hFB, 8'hFF, 0, 1);
      add(1046, 0, NUM_Q, 8'hFB, 8'hFF, 0, 1);
      run_vecs();

      // asynchronous reset mid-scan, outputs change without a clock edge
      #2 rst_n = 1'b0;
      #1;
      check("async_seg", seg, 8'hFF);
      check("async_sel", sel, 8'hFF);
      check("async_win", {6'd0, win_offset}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("restart_sel", sel, 8'h7F);
      check("restart_seg", seg, 8'hF9);
      check("restart_win", {6'd0, win_offset}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
